// File: rtl/lcd_hd44780_ctrl.sv
// rtl/lcd_hd44780_ctrl.sv - HD44780 character-LCD controller with power-on init and byte write port
// Purpose: runs the HD44780 power-on initialisation (8-bit or 4-bit bus), then writes
//   instruction/data bytes offered on a valid/ready handshake, generating E strobes and
//   per-command execution waits from CLK_HZ.
// Ports:
//   CLK, RST                    clock, asynchronous active-high reset
//   in_valid/in_ready           byte handshake; transfer when both high
//   in_rs, in_data              register select and byte for the transfer
//   reinit                      pulse in IDLE to rerun the initialisation
//   init_done                   display configured and accepting bytes
//   LCD_RS/LCD_RW/LCD_E/LCD_DB  panel pins (4-bit mode uses LCD_DB[7:4])
//   state_dbg                   main state: 0 power wait, 1..9 init, 10 idle, 11 user write
module lcd_hd44780_ctrl #(
  parameter int CLK_HZ     = 24000000,
  parameter int BUS_4BIT   = 0,
  parameter int TWO_LINE   = 1,
  parameter int FONT_5X11  = 1,
  parameter int POWERUP_US = 50000,
  parameter int E_CYC      = 6
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  input  logic       reinit,
  output logic       init_done,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic [7:0] LCD_DB,
  output logic [3:0] state_dbg
);
  localparam int US     = CLK_HZ / 1000000;
  localparam int T_PWR  = POWERUP_US * US;
  localparam int T_4100 = 4100 * US;
  localparam int T_1640 = 1640 * US;
  localparam int T_100  = 100 * US;
  localparam int T_42   = 42 * US;
  localparam int T_BIG  = (T_PWR > T_4100) ? T_PWR : T_4100;
  localparam int T_MAX  = (T_BIG > E_CYC) ? T_BIG : E_CYC;
  localparam int CW     = $clog2(T_MAX + 1);
  localparam logic [7:0] FSET = 8'h20 | ((BUS_4BIT != 0) ? 8'h00 : 8'h10)
                              | ((TWO_LINE != 0) ? 8'h08 : 8'h00)
                              | ((FONT_5X11 != 0) ? 8'h04 : 8'h00);

  typedef enum logic [3:0] {
    PWR_WAIT = 4'd0, INIT1 = 4'd1, INIT2 = 4'd2, INIT3 = 4'd3, INIT4 = 4'd4,
    INIT5 = 4'd5, INIT6 = 4'd6, INIT7 = 4'd7, INIT8 = 4'd8, INIT9 = 4'd9,
    IDLE = 4'd10, USER_WRITE = 4'd11
  } state_t;

  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_WAIT} phase_t;

  state_t        state;
  phase_t        phase;
  logic [CW-1:0] cnt;
  logic [7:0]    byte_q;
  logic          lo_nib;
  logic          long_wait;

  logic [CW-1:0] lim;
  logic          done;
  logic          single;
  state_t        nstate;
  logic [7:0]    nbyte;

  // First bus value of a byte: the whole byte, or its high nibble on DB[7:4].
  function automatic logic [7:0] first_bus(input logic [7:0] b);
    return (BUS_4BIT != 0) ? {b[7:4], 4'h0} : b;
  endfunction

  // Length of the phase in progress; the one counter runs 0..lim-1.
  always_comb begin
    lim = CW'(E_CYC);
    if (state == PWR_WAIT) begin
      lim = CW'(T_PWR);
    end else if (phase == PH_WAIT) begin
      case (state)
        INIT1:      lim = CW'(T_4100);
        INIT2:      lim = CW'(T_100);
        INIT7:      lim = CW'(T_1640);
        USER_WRITE: lim = long_wait ? CW'(T_1640) : CW'(T_42);
        default:    lim = CW'(T_42);
      endcase
    end
  end

  assign done = (cnt == lim - CW'(1));

  // The wake-up writes (and the 0x2 switch) are single nibbles on a 4-bit bus.
  assign single = (BUS_4BIT != 0) && (state inside {INIT1, INIT2, INIT3, INIT4});

  // Next init step; the 8-bit bus has no 4-bit switch step.
  always_comb begin
    nstate = state_t'(state + 4'd1);
    if (state == INIT3 && BUS_4BIT == 0) nstate = INIT5;
    case (nstate)
      INIT1, INIT2, INIT3: nbyte = 8'h30;
      INIT4:               nbyte = 8'h20;
      INIT5:               nbyte = FSET;
      INIT6:               nbyte = 8'h08;
      INIT7:               nbyte = 8'h01;
      INIT8:               nbyte = 8'h06;
      default:             nbyte = 8'h0C;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= PWR_WAIT;
      phase     <= PH_SETUP;
      cnt       <= '0;
      byte_q    <= 8'h00;
      lo_nib    <= 1'b0;
      long_wait <= 1'b0;
      in_ready  <= 1'b0;
      init_done <= 1'b0;
      LCD_RS    <= 1'b0;
      LCD_E     <= 1'b0;
      LCD_DB    <= 8'h00;
    end else begin
      case (state)
        PWR_WAIT: begin
          if (done) begin
            state  <= nstate;
            phase  <= PH_SETUP;
            cnt    <= '0;
            byte_q <= nbyte;
            lo_nib <= 1'b0;
            LCD_RS <= 1'b0;
            LCD_DB <= first_bus(nbyte);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        IDLE: begin
          if (reinit) begin
            state     <= PWR_WAIT;
            cnt       <= '0;
            in_ready  <= 1'b0;
            init_done <= 1'b0;
          end else if (in_valid) begin
            state     <= USER_WRITE;
            phase     <= PH_SETUP;
            cnt       <= '0;
            byte_q    <= in_data;
            lo_nib    <= 1'b0;
            // clear display / return home are the slow instructions
            long_wait <= !in_rs && (in_data[7:2] == 6'd0) && (in_data != 8'd0);
            LCD_RS    <= in_rs;
            LCD_DB    <= first_bus(in_data);
            in_ready  <= 1'b0;
          end
        end
        default: begin
          cnt <= done ? '0 : cnt + CW'(1);
          if (done) begin
            case (phase)
              PH_SETUP: begin
                LCD_E <= 1'b1;
                phase <= PH_PULSE;
              end
              PH_PULSE: begin
                LCD_E <= 1'b0;
                if (BUS_4BIT != 0 && !single && !lo_nib) begin
                  // low nibble goes out after an E_CYC setup gap, no exec wait
                  lo_nib <= 1'b1;
                  LCD_DB <= {byte_q[3:0], 4'h0};
                  phase  <= PH_SETUP;
                end else begin
                  phase <= PH_WAIT;
                end
              end
              default: begin
                if (state == USER_WRITE || state == INIT9) begin
                  state     <= IDLE;
                  in_ready  <= 1'b1;
                  init_done <= 1'b1;
                end else begin
                  state  <= nstate;
                  phase  <= PH_SETUP;
                  byte_q <= nbyte;
                  lo_nib <= 1'b0;
                  LCD_RS <= 1'b0;
                  LCD_DB <= first_bus(nbyte);
                end
              end
            endcase
          end
        end
      endcase
    end
  end

  assign LCD_RW    = 1'b0;
  assign state_dbg = state;

endmodule
